// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master arbiter and the master device it feeds.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int MCLK_DIV = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from last_owner+1.
module rr_arbiter
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
)
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               any,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        int cand;
        cand  = 0;
        any   = 1'b0;
        grant = '0;
        idx   = '0;
        // The previous owner is visited last, so a held request cannot starve the others.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_owner) + i) % NUM_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin sharing of one I2C master between NUM_REQ requesters.
// Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
)
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [ADDR_W*NUM_REQ-1:0] i_addr,
    input  logic [NUM_REQ-1:0]        i_rw,
    input  logic [DATA_W*NUM_REQ-1:0] i_data,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic [NUM_REQ-1:0]        o_done,
    output logic                      o_err,
    output logic                      o_m_enable,
    output logic [ADDR_W-1:0]         o_m_address,
    output logic                      o_m_rw,
    output logic [DATA_W-1:0]         o_m_data,
    input  logic                      i_m_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("i2c_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES 1..65535");
    end

    arb_state_t         state;
    logic [IDX_W-1:0]   last_owner;
    logic               busy_p0, busy_p1, busy_p2;
    logic               busy_rise;
    logic               pick_any;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (i_req),
        .last_owner (last_owner),
        .any        (pick_any),
        .grant      (pick_grant),
        .idx        (pick_idx)
    );

    // Stage p0/p1: busy synchronizer; p2 holds the previous synced value for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_p0 <= 1'b0;
            busy_p1 <= 1'b0;
            busy_p2 <= 1'b0;
        end else begin
            busy_p0 <= i_m_busy;
            busy_p1 <= busy_p0;
            busy_p2 <= busy_p1;
        end
    end

    // A rising edge is required so a busy left over from the previous stop is not taken as ours.
    assign busy_rise = busy_p1 & ~busy_p2;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] wdog;
    logic        wdog_hit;

    assign wdog_hit = (wdog == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || state == ST_IDLE || state == ST_RELEASE ||
            (state == ST_LAUNCH && busy_rise)) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 16'd1;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            last_owner  <= IDX_W'(NUM_REQ - 1);
            o_grant     <= '0;
            o_done      <= '0;
            o_err       <= 1'b0;
            o_m_enable  <= 1'b0;
            o_m_address <= '0;
            o_m_rw      <= 1'b0;
            o_m_data    <= '0;
        end else begin
            o_done <= '0;
            o_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state       <= ST_LAUNCH;
                        last_owner  <= pick_idx;
                        o_grant     <= pick_grant;
                        o_m_enable  <= 1'b1;
                        o_m_address <= i_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        o_m_rw      <= i_rw[pick_idx];
                        o_m_data    <= i_data[int'(pick_idx)*DATA_W +: DATA_W];
                    end
                end
                ST_LAUNCH: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    if (wdog_hit) begin
                        state      <= ST_RELEASE;
                        o_m_enable <= 1'b0;
                        o_done     <= o_grant;
                        o_err      <= 1'b1;
                    end else
`endif
                    if (busy_rise) begin
                        state      <= ST_ACTIVE;
                        o_m_enable <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    if (wdog_hit) begin
                        state      <= ST_RELEASE;
                        o_m_enable <= 1'b0;
                        o_done     <= o_grant;
                        o_err      <= 1'b1;
                    end else
`endif
                    if (!busy_p1) begin
                        state  <= ST_RELEASE;
                        o_done <= o_grant;
                    end
                end
                ST_RELEASE: begin
                    state   <= ST_IDLE;
                    o_grant <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    o_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter; covers the I2C_ARB_TIMEOUT_EN build when that macro is defined.
module tb_i2c_master_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [27:0] addr = '0;
    logic [3:0]  rw = '0;
    logic [31:0] data = '0;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        err;
    logic        m_enable;
    logic [6:0]  m_address;
    logic        m_rw;
    logic [7:0]  m_data;
    logic        m_busy = 1'b0;

    int checks = 0;
    int failures = 0;
    int done_cnt [4] = '{default: 0};
    int err_cnt = 0;
    int c;

    i2c_master_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_addr      (addr),
        .i_rw        (rw),
        .i_data      (data),
        .o_grant     (grant),
        .o_done      (done),
        .o_err       (err),
        .o_m_enable  (m_enable),
        .o_m_address (m_address),
        .o_m_rw      (m_rw),
        .o_m_data    (m_data),
        .i_m_busy    (m_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) if (done[k]) done_cnt[k]++;
        if (err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_busy = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int max, output int cyc);
        cyc = 0;
        while (grant == 4'b0 && cyc < max) begin
            tick(1);
            cyc++;
        end
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (done == 4'b0 && cyc < max);
    endtask

    task automatic run_busy(input int delay, input int hold);
        tick(delay);
        m_busy = 1'b1;
        tick(hold);
        m_busy = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(1);
        do_reset();
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_enable", m_enable, 0);
        check("rst_address", m_address, 0);
        check("rst_rw", m_rw, 0);
        check("rst_data", m_data, 0);

        // Single request from requester 1
        addr[13:7] = 7'h50;
        rw[1]      = 1'b0;
        data[15:8] = 8'hA5;
        req        = 4'b0010;
        wait_grant(10, c);
        check("t1_grant_latency", c, 1);
        check("t1_grant", grant, 4'b0010);
        check("t1_address", m_address, 7'h50);
        check("t1_data", m_data, 8'hA5);
        check("t1_rw", m_rw, 0);
        check("t1_enable_high", m_enable, 1);
        run_busy(6, 40);
        check("t1_enable_dropped", m_enable, 0);
        wait_done(10, c);
        check("t1_done_latency", c, 3);
        check("t1_done", done, 4'b0010);
        check("t1_err", err, 0);
        req = 4'b0;
        tick(1);
        check("t1_grant_cleared", grant, 0);
        check("t1_done_one_cycle", done, 0);
        tick(2);
        check("t1_done_count", done_cnt[1], 1);

        // Fairness with all four requesters held
        do_reset();
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_grant(10, c);
            check($sformatf("fair_grant_%0d", i), grant, 32'(1 << (i % 4)));
            run_busy(3, 10);
            wait_done(30, c);
            check($sformatf("fair_done_%0d", i), done, 32'(1 << (i % 4)));
            tick(1);
            check($sformatf("fair_idle_gap_%0d", i), grant, 0);
        end
        req = 4'b0;
        tick(2);

        // Payload captured at grant only; dropping req after grant does not abort
        do_reset();
        addr[6:0] = 7'h2A;
        rw[0]     = 1'b1;
        data[7:0] = 8'h11;
        req       = 4'b0001;
        wait_grant(10, c);
        check("pay_grant", grant, 4'b0001);
        check("pay_data_at_grant", m_data, 8'h11);
        check("pay_address", m_address, 7'h2A);
        check("pay_rw", m_rw, 1);
        tick(1);
        data[7:0] = 8'h22;
        req       = 4'b0;
        run_busy(4, 12);
        check("pay_data_active", m_data, 8'h11);
        wait_done(10, c);
        check("pay_done", done, 4'b0001);
        check("pay_data_at_done", m_data, 8'h11);
        tick(2);
        check("pay_no_regrant", grant, 0);

        // Stale busy: ACTIVE only after a fresh rising edge
        do_reset();
        m_busy = 1'b1;
        tick(3);
        addr[20:14] = 7'h33;
        req = 4'b0100;
        wait_grant(10, c);
        check("stale_grant", grant, 4'b0100);
        check("stale_address", m_address, 7'h33);
        tick(6);
        check("stale_hold_high", m_enable, 1);
        m_busy = 1'b0;
        tick(4);
        check("stale_hold_low", m_enable, 1);
        m_busy = 1'b1;
        tick(2);
        check("stale_before_edge", m_enable, 1);
        tick(1);
        check("stale_after_edge", m_enable, 0);
        tick(5);
        m_busy = 1'b0;
        wait_done(10, c);
        check("stale_done_latency", c, 3);
        check("stale_done", done, 4'b0100);
        req = 4'b0;
        tick(2);

        // Reset while ACTIVE; requester 0 wins afterwards even though last owner was 1
        do_reset();
        req = 4'b0010;
        wait_grant(10, c);
        check("rstact_grant", grant, 4'b0010);
        tick(3);
        m_busy = 1'b1;
        tick(4);
        check("rstact_in_active", m_enable, 0);
        req    = 4'b1001;
        rst    = 1'b1;
        m_busy = 1'b0;
        tick(1);
        check("rstact_grant_zero", grant, 0);
        check("rstact_address_zero", m_address, 0);
        check("rstact_data_zero", m_data, 0);
        check("rstact_enable_zero", m_enable, 0);
        rst = 1'b0;
        tick(1);
        check("rstact_next_grant", grant, 4'b0001);
        run_busy(3, 6);
        wait_done(10, c);
        check("rstact_done", done, 4'b0001);
        req = 4'b0;
        tick(2);

`ifdef I2C_ARB_TIMEOUT_EN
        // Watchdog: busy never rises
        do_reset();
        req = 4'b0001;
        wait_grant(10, c);
        check("to_grant", grant, 4'b0001);
        wait_done(40, c);
        check("to_latency_in_range", (c >= 32 && c <= 33), 1);
        check("to_done", done, 4'b0001);
        check("to_err", err, 1);
        check("to_enable_low", m_enable, 0);
        req = 4'b0;
        tick(2);
        check("to_err_count", err_cnt, 1);
`else
        check("no_err_pulses", err_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
